// File: rtl/demux_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : demux_sel_sequencer
// Description : Upstream driver for an 8-way demultiplexer. Sweeps the select
//               across the enabled channels, holding each channel for a
//               programmable dwell. Supports single-sweep and continuous
//               modes, a start/done handshake and a synchronous abort.
//               All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_sel_sequencer #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    cont,
  input  logic                    abort,
  input  logic [DWELL_W-1:0]      dwell,
  input  logic [(1<<SEL_W)-1:0]   en_mask,
  input  logic                    data_in,
  output logic                    demux_a,
  output logic [SEL_W-1:0]        demux_s,
  output logic                    valid,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        sweep_cnt
);

  localparam int NCH = 1 << SEL_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               demux_a_q, demux_a_d;
  logic [SEL_W-1:0]   demux_s_q, demux_s_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   sweep_cnt_q, sweep_cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic               cont_q, cont_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]     above_mask;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NCH-1:0] m);
    lowest_set = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = SEL_W'(i);
    end
  endfunction

  // Enabled channels strictly above the channel currently presented.
  always_comb begin
    above_mask = '0;
    for (int i = 0; i < NCH; i++) begin
      above_mask[i] = mask_q[i] && (i > int'(demux_s_q));
    end
  end

  // Next-state and next-output computation for the sweep sequencer.
  always_comb begin
    state_d     = state_q;
    demux_a_d   = 1'b0;
    demux_s_d   = demux_s_q;
    valid_d     = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    sweep_cnt_d = sweep_cnt_q;
    dwell_d     = dwell_q;
    mask_d      = mask_q;
    cont_d      = cont_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (!abort && start) begin
          if (|en_mask) begin
            // Zero dwell is promoted to one so every channel gets a cycle.
            dwell_d   = (dwell == '0) ? DWELL_W'(1) : dwell;
            mask_d    = en_mask;
            cont_d    = cont;
            state_d   = S_DWELL;
            demux_s_d = lowest_set(en_mask);
            cnt_d     = '0;
            valid_d   = 1'b1;
            busy_d    = 1'b1;
            demux_a_d = data_in;
          end else begin
            // Nothing enabled: finish immediately without a valid cycle.
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end

      S_DWELL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == dwell_q - DWELL_W'(1)) begin
          if (|above_mask) begin
            demux_s_d = lowest_set(above_mask);
            cnt_d     = '0;
            valid_d   = 1'b1;
            busy_d    = 1'b1;
            demux_a_d = data_in;
          end else begin
            sweep_cnt_d = sweep_cnt_q + CNT_W'(1);
            if (cont_q) begin
              demux_s_d = lowest_set(mask_q);
              cnt_d     = '0;
              valid_d   = 1'b1;
              busy_d    = 1'b1;
              demux_a_d = data_in;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b1;
            end
          end
        end else begin
          cnt_d     = cnt_q + DWELL_W'(1);
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          demux_a_d = data_in;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      demux_a_q   <= 1'b0;
      demux_s_q   <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sweep_cnt_q <= '0;
      dwell_q     <= '0;
      mask_q      <= '0;
      cont_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      demux_a_q   <= demux_a_d;
      demux_s_q   <= demux_s_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sweep_cnt_q <= sweep_cnt_d;
      dwell_q     <= dwell_d;
      mask_q      <= mask_d;
      cont_q      <= cont_d;
      cnt_q       <= cnt_d;
    end
  end

  assign demux_a   = demux_a_q;
  assign demux_s   = demux_s_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sweep_cnt = sweep_cnt_q;

endmodule
`default_nettype wire

// File: doc/demux_sel_sequencer.md
Name: demux_sel_sequencer

Overview:
Upstream driver for the 8-way demultiplexer. It sweeps the 3-bit select across the enabled channels and holds each channel for a programmable number of cycles, presenting a registered data bit with each select value. It supports single-sweep and continuous modes, a start/done handshake and a synchronous abort. Its outputs connect directly to the demux data and select inputs.

Parameters:
SEL_W, 3, select width; the channel count is 2**SEL_W = 8.
DWELL_W, 8, width of the dwell-count input and the internal dwell counter.
CNT_W, 8, width of the completed-sweep counter.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
start  input  1  request a sweep; sampled only in IDLE.
cont  input  1  continuous mode; latched with start.
abort  input  1  synchronous abort; return to IDLE.
dwell  input  DWELL_W  cycles per channel; latched with start; 0 is treated as 1.
en_mask  input  8  channel enable mask, bit i enables select i; latched with start.
data_in  input  1  data bit forwarded to the demux.
demux_a  output  1  registered data to the demux; 0 when not in DWELL.
demux_s  output  SEL_W  registered select to the demux.
valid  output  1  high while demux_a/demux_s drive a live channel.
busy  output  1  high in DWELL and DONE.
done  output  1  one-cycle pulse when a sweep sequence ends.
sweep_cnt  output  CNT_W  number of completed full sweeps; wraps modulo 2**CNT_W.

Behaviour:
- Reset (rst_n=0 at an edge) forces state IDLE and sets all outputs to 0:
  - demux_a=0, demux_s=0, valid=0, busy=0, done=0, sweep_cnt=0.
  - All latched registers (dwell_q, mask_q, cont_q, dwell counter) are cleared.
- Reset has priority over abort and start. Reset mid-sweep takes effect at that edge; no done pulse is produced.
- States: IDLE, DWELL, DONE.
- IDLE:
  - Outputs: valid=0, busy=0, demux_a=0; demux_s holds its last value.
  - On start=1 with en_mask!=0: latch dwell_q = max(dwell,1), mask_q, cont_q. At the next edge, enter DWELL with demux_s = lowest set bit of en_mask and the dwell counter = 0.
  - On start=1 with en_mask==0: go to DONE. No valid cycle occurs and sweep_cnt is unchanged.
  - Latency from start to the first valid cycle is 1 clock.
- DWELL:
  - Outputs: valid=1, busy=1, demux_a = data_in registered, so demux_a lags data_in by 1 cycle.
  - The dwell counter increments each cycle.
  - When counter == dwell_q-1, advance at the next edge:
    - If an enabled channel exists above demux_s: demux_s = next higher enabled channel; counter = 0.
    - Else, the sweep is complete: sweep_cnt increments.
      - If cont_q=1: demux_s = lowest enabled channel; counter = 0; remain in DWELL.
      - If cont_q=0: go to DONE.
  - Each enabled channel is valid for exactly dwell_q consecutive cycles. Disabled channels are never presented.
  - start is ignored while busy.
  - Inputs dwell, en_mask and cont are ignored after they are latched.
- DONE: lasts one cycle with done=1, busy=1, valid=0, demux_a=0. Then IDLE. A start asserted in DONE is ignored.
- Abort: abort=1 in DWELL or DONE returns to IDLE at the next edge.
  - valid, demux_a and busy drop to 0.
  - No done pulse; sweep_cnt is unchanged.
  - In IDLE, abort has priority over start.
- sweep_cnt at all-ones increments to 0 (wrap, no saturation).
- Single-channel mask with cont=1: demux_s stays constant and sweep_cnt increments every dwell_q cycles.

Test Plan:
- Reset check: rst_n=0 for 2 cycles mid-sweep -> all outputs 0 at the next edge; no done pulse.
- Single sweep: en_mask=8'hFF, dwell=2, cont=0, data_in=1, start pulse -> demux_s=0,0,1,1,…,7,7 over 16 valid cycles with demux_a=1; done pulses on cycle 17; sweep_cnt=1.
- Sparse mask with zero dwell: en_mask=8'b1010_0100, dwell=0 -> demux_s=2,5,7, one cycle each; then done.
- Continuous mode with abort: en_mask=8'h81, dwell=3, cont=1 -> demux_s=0×3, 7×3, 0×3… with sweep_cnt incrementing every 6 cycles; abort on the 20th valid cycle -> IDLE next cycle, no done, sweep_cnt=3.
- Empty mask: start with en_mask=0 -> done pulse 1 cycle after start; valid never asserts; sweep_cnt unchanged.
- Busy and counter wrap: start re-asserted during DWELL is ignored (sequence unchanged); with cont=1, after 256 sweeps sweep_cnt wraps from 255 to 0.
